fifo_sync_thresh: RTL and testbench

FIFO_SYNC_THRESH -- requirements
Module: fifo_sync_thresh

---
 rtl/fifo_sync_thresh_pkg.sv | 13 +
 rtl/dpram_sync.sv | 35 +++
 rtl/fifo_sync_thresh.sv | 126 ++++++++++++
 tb/tb_fifo_sync_thresh.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_thresh_pkg.sv
// Shared defaults for the threshold FIFO.
// Optional sticky error flags are enabled by defining FIFO_SYNC_THRESH_ERR_EN.
package fifo_sync_thresh_pkg;

    localparam int unsigned DW_DEF        = 40;
    localparam int unsigned AW_DEF        = 9;
    // almost_full default is DEPTH minus this margin
    localparam int unsigned AF_MARGIN_DEF = 4;
    localparam int unsigned AE_LVL_DEF    = 4;

    localparam string ERR_EN_MACRO = "FIFO_SYNC_THRESH_ERR_EN";

endpackage

// File: rtl/dpram_sync.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero and holds its value when no read is issued.
module dpram_sync #(
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned DWIDTH = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [0:(1 << AWIDTH)-1];

    // Storage array; no reset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with registered full/empty and almost-full/almost-empty flags.
// Define FIFO_SYNC_THRESH_ERR_EN to build the sticky overflow/underflow flags.
module fifo_sync_thresh
    import fifo_sync_thresh_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned AF_LVL = (1 << AW) - AF_MARGIN_DEF,
    parameter int unsigned AE_LVL = AE_LVL_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LVL);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q, dout_vld_q;
    logic          wr_acc, rd_acc;

    // Accept logic and next occupancy; a read frees the slot a same-cycle write needs.
    always_comb begin
        rd_acc  = re & ~empty_q;
        wr_acc  = we & (~full_q | rd_acc);
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and flags; clr overrides any same-cycle access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            dout_vld_q <= 1'b0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= (AF_CNT == '0);
            ae_q       <= 1'b1;
            dout_vld_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_CNT);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= AF_CNT);
            ae_q       <= (count_d <= AE_CNT);
            dout_vld_q <= rd_acc;
        end
    end

    dpram_sync #(
        .AWIDTH (AW),
        .DWIDTH (DW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc & ~clr),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc & ~clr),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign dout_vld     = dout_vld_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

`ifdef FIFO_SYNC_THRESH_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error capture: rejected write, or read request while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (we && !wr_acc) overflow_q  <= 1'b1;
            if (re && empty_q) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Self-checking bench for fifo_sync_thresh at DW=8, AW=2, AF_LVL=3, AE_LVL=1.
// Flag/count expectations come from a vector table and a queue model;
// read data is checked through a scoreboard of expected words.
module tb_fifo_sync_thresh;

`ifdef FIFO_SYNC_THRESH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk, rst_n, clr, we, re;
    logic [7:0] din, dout;
    logic       dout_vld, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    fifo_sync_thresh #(
        .DW     (8),
        .AW     (2),
        .AF_LVL (3),
        .AE_LVL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .din          (din),
        .we           (we),
        .re           (re),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we, re, clr;
        logic [7:0] din;
        logic [2:0] cnt;
        logic       full, empty, af, ae, ovf, unf;
    } vec_t;

    vec_t       vt [21];
    logic [7:0] mq [$];   // model FIFO contents
    logic [7:0] sb [$];   // expected dout words, in order
    logic       m_ovf, m_unf;
    int         n_checks, n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; updates the model and checks read data.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic rd_ok, wr_ok;
        we = w; re = r; clr = c; din = d;
        rd_ok = r && (mq.size() > 0);
        wr_ok = w && ((mq.size() < 4) || rd_ok);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && mq.size() == 0) m_unf = 1'b1;
            if (rd_ok) sb.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; re = 1'b0; clr = 1'b0;
        chk("dout_vld", dout_vld, sb.size() > 0);
        if (dout_vld && sb.size() > 0) chk("dout", dout, sb.pop_front());
        else if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("count", count, n);
        chk("full", full, n == 4);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, n >= 3);
        chk("almost_empty", almost_empty, n <= 1);
        chk("overflow", overflow, ERR_EN & m_ovf);
        chk("underflow", underflow, ERR_EN & m_unf);
    endtask

    task automatic check_reset_vals();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;

        //       we re clr din    cnt full empty af ae ovf unf  (ovf/unf: error flags built)
        vt[0]  = '{1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0};
        vt[1]  = '{1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{1, 0, 0, 8'h44, 4, 1, 0, 1, 0, 0, 0};
        vt[4]  = '{1, 0, 0, 8'h55, 4, 1, 0, 1, 0, 1, 0};
        vt[5]  = '{0, 1, 0, 8'h00, 3, 0, 0, 1, 0, 1, 0};
        vt[6]  = '{0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 0};
        vt[7]  = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0};
        vt[8]  = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0};
        vt[9]  = '{1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 1, 0};
        vt[10] = '{1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 1, 0};
        vt[11] = '{1, 0, 0, 8'h03, 3, 0, 0, 1, 0, 1, 0};
        vt[12] = '{1, 0, 0, 8'h04, 4, 1, 0, 1, 0, 1, 0};
        vt[13] = '{1, 1, 0, 8'h66, 4, 1, 0, 1, 0, 1, 0};
        vt[14] = '{0, 1, 0, 8'h00, 3, 0, 0, 1, 0, 1, 0};
        vt[15] = '{0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 0};
        vt[16] = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0};
        vt[17] = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0};
        vt[18] = '{1, 1, 0, 8'h77, 1, 0, 0, 0, 1, 1, 1};
        vt[19] = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1};
        vt[20] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0};

        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Fill/overflow/drain, full with simultaneous read+write, empty read+write, clr
        for (int i = 0; i < 21; i++) begin
            step(vt[i].we, vt[i].re, vt[i].clr, vt[i].din);
            chk($sformatf("v%0d_count", i), count, vt[i].cnt);
            chk($sformatf("v%0d_full", i), full, vt[i].full);
            chk($sformatf("v%0d_empty", i), empty, vt[i].empty);
            chk($sformatf("v%0d_afull", i), almost_full, vt[i].af);
            chk($sformatf("v%0d_aempty", i), almost_empty, vt[i].ae);
            chk($sformatf("v%0d_overflow", i), overflow, ERR_EN & vt[i].ovf);
            chk($sformatf("v%0d_underflow", i), underflow, ERR_EN & vt[i].unf);
        end

        // Pointer wrap: two rounds of six streamed words, then drain
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                step(1'b1, (i % 2) == 1, 1'b0, 8'($urandom_range(0, 255)));
                check_model();
            end
            while (mq.size() > 0) begin
                step(1'b0, 1'b1, 1'b0, 8'h00);
                check_model();
            end
        end
        chk("wrap_empty_end", empty, 1);

        // Async reset while a read is in flight
        step(1'b1, 1'b0, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 1'b0, 8'hA2);
        re = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        re = 1'b0;
        mq.delete(); sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Underflow, refill, one read, then clr: everything back except dout holds
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check_model();
        step(1'b1, 1'b0, 1'b0, 8'hB1);
        step(1'b1, 1'b0, 1'b0, 8'hB2);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check_model();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_aempty", almost_empty, 1);
        chk("clr_full", full, 0);
        chk("clr_afull", almost_full, 0);
        chk("clr_dout_vld", dout_vld, 0);
        chk("clr_dout_hold", dout, 8'hB1);
        chk("clr_overflow", overflow, 0);
        chk("clr_underflow", underflow, 0);
        // Data written after clr starts fresh at the head
        step(1'b1, 1'b0, 1'b0, 8'hC3);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check_model();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
